// File: rtl/fazyrv_mem_pkg.sv
// Shared types for the FazyRV memory responder: FSM states, grant encoding, SRAM timing.
package fazyrv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/fazyrv_mem_arb.sv
// 2:1 fixed-priority arbiter (dmem wins) with the matching request field mux.
module fazyrv_mem_arb
    import fazyrv_mem_pkg::*;
(
    input  logic        imem_stb,
    input  logic [31:0] imem_adr,
    input  logic        dmem_stb,
    input  logic        dmem_we,
    input  logic [3:0]  dmem_be,
    input  logic [31:0] dmem_adr,
    input  logic [31:0] dmem_wdat,
    output gnt_t        gnt,
    output logic [31:0] adr,
    output logic        we,
    output logic [3:0]  be,
    output logic [31:0] wdat
);

    always_comb begin
        gnt  = GNT_NONE;
        adr  = imem_adr;
        we   = 1'b0;
        be   = 4'hF;
        wdat = '0;
        if (dmem_stb) begin
            gnt  = GNT_D;
            adr  = dmem_adr;
            we   = dmem_we;
            be   = dmem_be;
            wdat = dmem_wdat;
        end else if (imem_stb) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/fazyrv_mem_resp.sv
// imem/dmem strobe-ack responder in front of a 1-cycle-latency single-port SRAM.
// Optional bus-error reporting for out-of-range addresses: FAZYRV_MEM_RESP_BUSERR_EN.
module fazyrv_mem_resp
    import fazyrv_mem_pkg::*;
#(
    parameter int ADR_WIDTH   = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 imem_stb_i,
    input  logic [31:0]          imem_adr_i,
    output logic [31:0]          imem_dat_o,
    output logic                 imem_ack_o,
    input  logic                 dmem_stb_i,
    input  logic                 dmem_we_i,
    input  logic [3:0]           dmem_be_i,
    input  logic [31:0]          dmem_adr_i,
    input  logic [31:0]          dmem_dat_i,
    output logic [31:0]          dmem_dat_o,
    output logic                 dmem_ack_o,
    output logic                 ram_cs_o,
    output logic                 ram_we_o,
    output logic [3:0]           ram_be_o,
    output logic [ADR_WIDTH-1:0] ram_adr_o,
    output logic [31:0]          ram_wdat_o,
    input  logic [31:0]          ram_rdat_i,
`ifdef FAZYRV_MEM_RESP_BUSERR_EN
    output logic                 imem_err_o,
    output logic                 dmem_err_o,
`endif
    output state_t               dbg_state_o
);

    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t state, state_nxt;
    gnt_t   gnt, arb_gnt;
    logic [3:0] wait_cnt, wait_cnt_nxt;

    logic [31:0] arb_adr, arb_wdat;
    logic [3:0]  arb_be;
    logic        arb_we, arb_err;

    logic [ADR_WIDTH-1:0] lat_adr;
    logic [31:0]          lat_wdat;
    logic [3:0]           lat_be;
    logic                 lat_we, lat_err;
    logic                 gstb, resp;
    logic                 unused_adr;

    fazyrv_mem_arb u_arb (
        .imem_stb  (imem_stb_i),
        .imem_adr  (imem_adr_i),
        .dmem_stb  (dmem_stb_i),
        .dmem_we   (dmem_we_i),
        .dmem_be   (dmem_be_i),
        .dmem_adr  (dmem_adr_i),
        .dmem_wdat (dmem_dat_i),
        .gnt       (arb_gnt),
        .adr       (arb_adr),
        .we        (arb_we),
        .be        (arb_be),
        .wdat      (arb_wdat)
    );

`ifdef FAZYRV_MEM_RESP_BUSERR_EN
    assign arb_err    = |arb_adr[31:ADR_WIDTH+2];
    assign unused_adr = ^arb_adr[1:0];
`else
    // Upper address bits are dropped so accesses wrap modulo the RAM size.
    assign arb_err    = 1'b0;
    assign unused_adr = ^{arb_adr[31:ADR_WIDTH+2], arb_adr[1:0]};
`endif

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            wait_cnt <= '0;
            gnt      <= GNT_NONE;
            lat_adr  <= '0;
            lat_we   <= 1'b0;
            lat_be   <= '0;
            lat_wdat <= '0;
            lat_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // Request fields are frozen once the FSM leaves IDLE.
            if (state == IDLE) begin
                gnt      <= arb_gnt;
                lat_adr  <= arb_adr[ADR_WIDTH+1:2];
                lat_we   <= arb_we;
                lat_be   <= arb_be;
                lat_wdat <= arb_wdat;
                lat_err  <= arb_err;
            end
        end
    end

    always_comb begin
        gstb = 1'b0;
        case (gnt)
            GNT_I:   gstb = imem_stb_i;
            GNT_D:   gstb = dmem_stb_i;
            default: gstb = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (arb_gnt != GNT_NONE)
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ISSUE;
            end
            WAIT: begin
                if (!gstb)
                    state_nxt = IDLE;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = ISSUE;
                else
                    wait_cnt_nxt = wait_cnt + 4'd1;
            end
            ISSUE:   state_nxt = gstb ? RESP : IDLE;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A withdrawn strobe gates both the SRAM access and the acknowledge.
    assign ram_cs_o   = (state == ISSUE) && gstb && !lat_err;
    assign ram_we_o   = ram_cs_o && lat_we;
    assign ram_be_o   = lat_we ? lat_be : 4'hF;
    assign ram_adr_o  = lat_adr;
    assign ram_wdat_o = lat_wdat;

    assign resp       = (state == RESP) && gstb;
    assign imem_ack_o = resp && (gnt == GNT_I) && !lat_err;
    assign dmem_ack_o = resp && (gnt == GNT_D) && !lat_err;
    assign imem_dat_o = imem_ack_o ? ram_rdat_i : '0;
    assign dmem_dat_o = (dmem_ack_o && !lat_we) ? ram_rdat_i : '0;

`ifdef FAZYRV_MEM_RESP_BUSERR_EN
    assign imem_err_o = resp && (gnt == GNT_I) && lat_err;
    assign dmem_err_o = resp && (gnt == GNT_D) && lat_err;
`endif

    assign dbg_state_o = state;

endmodule
